// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit: FSM state encoding,
// the read-timeout fill pattern and the parameter legality check.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Sliced down to DATA_W where used; wide enough for any supported bus.
    localparam logic [63:0] ERR_FILL = '1;

    function automatic bit params_ok(input int data_w, input int addr_w,
                                     input int wait_cycles, input int timeout);
        return (addr_w >= 1) && (addr_w <= data_w) && (data_w <= 64) &&
               (wait_cycles >= 1) && (timeout > wait_cycles);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating ACCESS-cycle counter: reports when the minimum wait has elapsed
// and when the access has run out of time.
module mem_wait_timer #(
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic min_met,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign min_met = (r_cnt >= CNT_MIN);
    assign expired = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR register pair plus the self-timed memory access sequencer that
// handles wait states, ready handshake and timeout for the control FSM.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MIO_EN,
    input  logic [DATA_W-1:0] Bus_in,
    input  logic              Mem_start,
    input  logic              Mem_wr,
    output logic [ADDR_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic              Busy,
    output logic              R,
    output logic              Err,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    output logic              Mem_ce,
    output logic              Mem_we,
    input  logic [DATA_W-1:0] Mem_rdata,
    input  logic              Mem_ready
);

    if (!params_ok(DATA_W, ADDR_W, WAIT_CYCLES, TIMEOUT)) begin : g_bad_params
        $error("mem_access_unit: illegal DATA_W/ADDR_W/WAIT_CYCLES/TIMEOUT combination");
    end

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_wr;
    logic              r_err;
    logic              w_accept;
    logic              w_complete;
    logic              w_timeout;
    logic              w_min_met;
    logic              w_expired;
    logic              w_idle;

    mem_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .clk    (Clk),
        .rst_n  (Reset),
        .clr    (w_accept),
        .en     (r_state == ACCESS),
        .min_met(w_min_met),
        .expired(w_expired)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (Mem_start) begin
                    w_accept = 1'b1;
                    w_next   = ACCESS;
                end
            end
            ACCESS: begin
                // Completion wins over timeout when both land on the same edge.
                if (w_min_met && Mem_ready) begin
                    w_complete = 1'b1;
                    w_next     = DONE;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_idle = (r_state == IDLE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_mar <= '0;
            r_mdr <= '0;
            r_wr  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_idle && LD_MAR) r_mar <= Bus_in[ADDR_W-1:0];
            if (w_idle && LD_MDR && !MIO_EN)  r_mdr <= Bus_in;
            else if (w_complete && !r_wr)     r_mdr <= Mem_rdata;
            else if (w_timeout && !r_wr)      r_mdr <= ERR_FILL[DATA_W-1:0];
            if (w_accept) begin
                r_wr  <= Mem_wr;
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Handshake outputs decode only from registered state.
    assign Mem_ce    = (r_state == ACCESS);
    assign Mem_we    = Mem_ce & r_wr;
    assign Busy      = !w_idle;
    assign R         = (r_state == DONE);
    assign Err       = r_err;
    assign MAR       = r_mar;
    assign MDR       = r_mdr;
    assign Mem_addr  = r_mar;
    assign Mem_wdata = r_mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, multi-cycle corner
// sequences and randomized accesses checked against a behavioural model.
module tb_mem_access_unit;

    localparam int WAITC = 2;
    localparam int TMO   = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LD_MAR, LD_MDR, MIO_EN, Mem_start, Mem_wr, Mem_ready;
    logic [15:0] Bus_in, Mem_rdata;
    logic [15:0] MAR, MDR, Mem_addr, Mem_wdata;
    logic        Busy, R, Err, Mem_ce, Mem_we;

    logic        b_LD_MAR, b_LD_MDR, b_MIO_EN, b_Mem_start, b_Mem_wr, b_Mem_ready;
    logic [31:0] b_Bus_in, b_Mem_rdata, b_MDR, b_Mem_wdata;
    logic [19:0] b_MAR, b_Mem_addr;
    logic        b_Busy, b_R, b_Err, b_Mem_ce, b_Mem_we;

    int nchk = 0;
    int nerr = 0;
    bit exp_err_now = 0;

    always #5 Clk = ~Clk;

    mem_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(WAITC), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MIO_EN(MIO_EN),
        .Bus_in(Bus_in), .Mem_start(Mem_start), .Mem_wr(Mem_wr), .MAR(MAR), .MDR(MDR),
        .Busy(Busy), .R(R), .Err(Err), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
        .Mem_ce(Mem_ce), .Mem_we(Mem_we), .Mem_rdata(Mem_rdata), .Mem_ready(Mem_ready)
    );

    mem_access_unit #(.DATA_W(32), .ADDR_W(20), .WAIT_CYCLES(WAITC), .TIMEOUT(TMO)) dut32 (
        .Clk(Clk), .Reset(Reset), .LD_MAR(b_LD_MAR), .LD_MDR(b_LD_MDR), .MIO_EN(b_MIO_EN),
        .Bus_in(b_Bus_in), .Mem_start(b_Mem_start), .Mem_wr(b_Mem_wr), .MAR(b_MAR), .MDR(b_MDR),
        .Busy(b_Busy), .R(b_R), .Err(b_Err), .Mem_addr(b_Mem_addr), .Mem_wdata(b_Mem_wdata),
        .Mem_ce(b_Mem_ce), .Mem_we(b_Mem_we), .Mem_rdata(b_Mem_rdata), .Mem_ready(b_Mem_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mask_from(input int rf);
        logic [31:0] m;
        for (int k = 0; k < 32; k++) m[k] = (k >= rf);
        return m;
    endfunction

    // Reference: first cycle n in [WAIT, TIMEOUT] with ready completes; else timeout at TIMEOUT.
    task automatic model(input bit wr, input logic [15:0] mdr, input logic [15:0] rdata,
                         input logic [31:0] mask, output int n_r,
                         output logic [15:0] e_mdr, output bit e_err);
        int n;
        n = TMO;
        e_err = 1'b1;
        for (int k = TMO; k >= WAITC; k--) begin
            if (mask[k]) begin
                n = k;
                e_err = 1'b0;
            end
        end
        n_r   = n + 1;
        e_mdr = wr ? mdr : (e_err ? 16'hFFFF : rdata);
    endtask

    // MAR load one edge ahead, then MDR load and start on the same edge (edge 0).
    task automatic do_access(input bit wr, input logic [15:0] mar, input logic [15:0] mdr,
                             input logic [15:0] rdata, input logic [31:0] mask,
                             output int rc, output logic [15:0] mdr_r, output bit err_r);
        bit bus_bad;
        bus_bad = 1'b0;
        rc      = 0;
        mdr_r   = '0;
        err_r   = 1'b0;
        @(negedge Clk);
        LD_MAR = 1'b1; LD_MDR = 1'b0; Bus_in = mar;
        @(negedge Clk);
        chk("err_before_start", Err, exp_err_now);
        LD_MAR = 1'b0; LD_MDR = 1'b1; MIO_EN = 1'b0; Bus_in = mdr;
        Mem_start = 1'b1; Mem_wr = wr; Mem_rdata = rdata; Mem_ready = 1'b0;
        for (int k = 1; k <= TMO + 4 && rc == 0; k++) begin
            @(negedge Clk);
            LD_MDR = 1'b0; Mem_start = 1'b0; Mem_wr = ~wr; Bus_in = 16'($urandom);
            if (k == 1) begin
                chk("ce_cycle1", Mem_ce, 1'b1);
                chk("err_cleared_on_start", Err, 1'b0);
            end
            if (Mem_ce && (Mem_addr !== mar || Mem_wdata !== mdr || Mem_we !== wr)) bus_bad = 1'b1;
            if (R) begin
                rc    = k;
                mdr_r = MDR;
                err_r = Err;
            end
            Mem_ready = mask[k];
        end
        chk("bus_during_access", bus_bad, 1'b0);
        @(negedge Clk);
        chk("r_one_cycle", R, 1'b0);
        chk("idle_after_done", Busy, 1'b0);
        chk("mar_stable", MAR, mar);
        Mem_ready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] mar, mdr, rdata;
        int          rf;
        int          exp_r;
        logic [15:0] exp_mdr;
        bit          exp_err;
    } vec_t;

    vec_t vt[8];

    initial begin
        int          rc, n_r, rcount;
        logic [15:0] mdr_r, e_mdr, mar_r;
        bit          err_r, e_err, wr;
        logic [31:0] mask;
        logic [15:0] mdr_before;
        bit          got_r;

        vt[0] = '{1'b1, 16'h3000, 16'hBEEF, 16'h0000, 1,  3,  16'hBEEF, 1'b0};
        vt[1] = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 5,  6,  16'h1234, 1'b0};
        vt[2] = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 99, 17, 16'hFFFF, 1'b1};
        vt[3] = '{1'b0, 16'h0022, 16'h0000, 16'h5A5A, 1,  3,  16'h5A5A, 1'b0};
        vt[4] = '{1'b1, 16'h0033, 16'h7777, 16'h1111, 99, 17, 16'h7777, 1'b1};
        vt[5] = '{1'b0, 16'h0044, 16'h0000, 16'hC0DE, 16, 17, 16'hC0DE, 1'b0};
        vt[6] = '{1'b0, 16'h0055, 16'h0000, 16'h0F0F, 2,  3,  16'h0F0F, 1'b0};
        vt[7] = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 3,  4,  16'hA5A5, 1'b0};

        Reset = 1'b0;
        {LD_MAR, LD_MDR, MIO_EN, Mem_start, Mem_wr, Mem_ready} = '0;
        Bus_in = '0; Mem_rdata = '0;
        {b_LD_MAR, b_LD_MDR, b_MIO_EN, b_Mem_start, b_Mem_wr, b_Mem_ready} = '0;
        b_Bus_in = '0; b_Mem_rdata = '0;
        #2;
        chk("rst_mar", MAR, 16'h0);
        chk("rst_mdr", MDR, 16'h0);
        chk("rst_ctl", {Busy, R, Err, Mem_ce, Mem_we}, 5'b0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        // LD_MDR is ignored while memory owns MDR.
        @(negedge Clk);
        LD_MDR = 1'b1; MIO_EN = 1'b1; Bus_in = 16'h1111;
        @(negedge Clk);
        LD_MDR = 1'b0; MIO_EN = 1'b0;
        chk("ld_mdr_mio_ignored", MDR, 16'h0);

        foreach (vt[i]) begin
            do_access(vt[i].wr, vt[i].mar, vt[i].mdr, vt[i].rdata, mask_from(vt[i].rf),
                      rc, mdr_r, err_r);
            chk($sformatf("vec%0d_r_cycle", i), rc, vt[i].exp_r);
            chk($sformatf("vec%0d_mdr", i), mdr_r, vt[i].exp_mdr);
            chk($sformatf("vec%0d_err", i), err_r, vt[i].exp_err);
            exp_err_now = vt[i].exp_err;
        end

        // Loads and starts while busy are ignored; start during R is ignored too.
        @(negedge Clk);
        LD_MAR = 1'b1; Bus_in = 16'h0020;
        @(negedge Clk);
        LD_MAR = 1'b0; Mem_start = 1'b1; Mem_wr = 1'b0; Mem_rdata = 16'h0BAD; Mem_ready = 1'b0;
        rcount = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge Clk);
            LD_MAR = 1'b0; LD_MDR = 1'b0; Mem_start = 1'b0;
            if (R) rcount++;
            if (k == 2) begin
                LD_MAR = 1'b1; LD_MDR = 1'b1; Bus_in = 16'h4000; Mem_start = 1'b1;
            end
            if (k == 5) begin
                chk("busy_r_cycle", R, 1'b1);
                Mem_start = 1'b1;
            end
            if (k == 6) chk("start_in_r_ignored", Busy, 1'b0);
            Mem_ready = (k >= 4);
        end
        Mem_ready = 1'b0;
        chk("busy_single_r", rcount, 1);
        chk("busy_mar_unchanged", MAR, 16'h0020);
        chk("busy_mdr_read", MDR, 16'h0BAD);
        exp_err_now = 1'b0;

        // Randomized accesses against the model.
        for (int it = 0; it < 40; it++) begin
            wr    = 1'($urandom_range(0, 1));
            mar_r = 16'($urandom);
            mdr_before = 16'($urandom);
            Mem_rdata  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) mask = mask_from($urandom_range(1, 20));
            else                           mask = $urandom & $urandom & $urandom;
            model(wr, mdr_before, Mem_rdata, mask, n_r, e_mdr, e_err);
            do_access(wr, mar_r, mdr_before, Mem_rdata, mask, rc, mdr_r, err_r);
            chk($sformatf("rnd%0d_r_cycle", it), rc, n_r);
            chk($sformatf("rnd%0d_mdr", it), mdr_r, e_mdr);
            chk($sformatf("rnd%0d_err", it), err_r, e_err);
            exp_err_now = e_err;
        end

        // Reset asserted in ACCESS cycle 2 drops the handshake immediately.
        @(negedge Clk);
        LD_MAR = 1'b1; Bus_in = 16'h0010;
        @(negedge Clk);
        LD_MAR = 1'b0; Mem_start = 1'b1; Mem_wr = 1'b0; Mem_ready = 1'b0;
        @(negedge Clk);
        Mem_start = 1'b0;
        @(negedge Clk);
        chk("pre_reset_ce", Mem_ce, 1'b1);
        Reset = 1'b0;
        #1;
        chk("midrst_ce", Mem_ce, 1'b0);
        chk("midrst_mar", MAR, 16'h0);
        chk("midrst_mdr", MDR, 16'h0);
        chk("midrst_busy", Busy, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        got_r = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            if (R) got_r = 1'b1;
        end
        chk("midrst_no_r", got_r, 1'b0);

        // Wide instance: MAR truncation and full-width read capture.
        @(negedge Clk);
        b_LD_MAR = 1'b1; b_Bus_in = 32'hABCDE123;
        @(negedge Clk);
        b_LD_MAR = 1'b0; b_Mem_start = 1'b1; b_Mem_wr = 1'b0;
        b_Mem_rdata = 32'h89ABCDEF; b_Mem_ready = 1'b1;
        chk("w32_mar", b_MAR, 20'hDE123);
        rc = 0;
        for (int k = 1; k <= 10 && rc == 0; k++) begin
            @(negedge Clk);
            b_Mem_start = 1'b0;
            if (b_R) begin
                rc = k;
                chk("w32_mdr", b_MDR, 32'h89ABCDEF);
            end
        end
        chk("w32_r_cycle", rc, 3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
